// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Program-counter sequencer for a small instruction ROM. After a start pulse
// the controller walks the ROM from START_ADDR, following absolute or
// relative branches, holding on stall and stopping on halt.
//
// Optional feature macro: FETCH_CTRL_INSTR_CNT_EN
//   defined   -> instr_cnt is a saturating count of valid fetches,
//                cleared on every accepted start
//   undefined -> no counter register; instr_cnt is tied to zero
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begin execution (honoured in IDLE/DONE only)
//   stall        in   hold prog_ctr this cycle
//   halt         in   end program (decoded from instruction at prog_ctr)
//   branch_en    in   take a branch this cycle
//   branch_abs   in   1 = absolute target, 0 = relative offset
//   target       in   absolute branch address [D-1:0]
//   offset       in   signed relative branch offset [7:0]
//   prog_ctr     out  registered ROM address [D-1:0]
//   fetch_valid  out  instruction at prog_ctr is live this cycle
//   busy         out  registered, high in RUN
//   done         out  registered, high in DONE
//   instr_cnt    out  valid-fetch count [15:0]
//
// States
//   IDLE | waiting for start after reset
//   RUN  | fetching; halt > stall > branch > sequential
//   DONE | program ended by halt; waiting for a restart
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_en,
    input  logic         branch_abs,
    input  logic [D-1:0] target,
    input  logic [7:0]   offset,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_valid,
    output logic         busy,
    output logic         done,
    output logic [15:0]  instr_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    // Sign-extend (or truncate, for very narrow D) the relative offset so the
    // add below wraps naturally modulo 2^D.
    logic [D-1:0] off_ext;
    assign off_ext = D'($signed(offset));

    // Next-state decode. Strict priority inside RUN: halt, stall, branch,
    // sequential. A branch coincident with stall is simply dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_en) begin
                    pc_d = branch_abs ? target : (pc_q + off_ext);
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign prog_ctr    = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    // state_q is forced to IDLE by reset, so this is low while reset is high.
    assign fetch_valid = (state_q == RUN) && !stall && !halt;

`ifdef FETCH_CTRL_INSTR_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        start_accept;

    // start is only honoured outside RUN, and fetch_valid is only high in
    // RUN, so clear and increment never coincide.
    assign start_accept = (state_q != RUN) && start;

    always_comb begin
        cnt_d = cnt_q;
        if (start_accept) begin
            cnt_d = 16'h0000;
        end else if (fetch_valid && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign instr_cnt = cnt_q;
`else
    assign instr_cnt = 16'h0000;
`endif

endmodule
